// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/issue sequencer stepping a program from instruction memory to a processor
module fetch_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Pclk,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic [DATA_W-1:0] Mem_data,
    output logic [DATA_W-1:0] Instr,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] Counter,
    output logic              Busy,
    output logic              Halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] counter_q, counter_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        instr_d   = instr_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                instr_d = Mem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (Done) begin
                    if (counter_q == LAST_ADDR) begin
                        state_d = S_HALT;
                    end else begin
                        counter_d = counter_q + 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (Start) begin
                    counter_d = '0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they track the state flop exactly.
        run_d    = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge Pclk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            instr_q   <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            instr_q   <= instr_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign Mem_addr = counter_q;
    assign Counter  = counter_q;
    assign Instr    = instr_q;
    assign Run      = run_q;
    assign Busy     = busy_q;
    assign Halted   = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        Pclk;
    logic        Reset;
    logic        Start;
    logic [3:0]  Mem_addr;
    logic [15:0] Mem_data;
    logic [15:0] Instr;
    logic        Run;
    logic        Done;
    logic [3:0]  Counter;
    logic        Busy;
    logic        Halted;

    int errors;
    int checks;
    logic [15:0] exp_q[$];

    fetch_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
        .Pclk     (Pclk),
        .Reset    (Reset),
        .Start    (Start),
        .Mem_addr (Mem_addr),
        .Mem_data (Mem_data),
        .Instr    (Instr),
        .Run      (Run),
        .Done     (Done),
        .Counter  (Counter),
        .Busy     (Busy),
        .Halted   (Halted)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    // Synchronous instruction memory: data for an address appears one cycle later.
    always @(posedge Pclk) Mem_data <= 16'hA000 + {12'h000, Mem_addr};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Done  = 1'b0;
        #1;
        chk("rst_counter", {12'h0, Counter}, 16'h0);
        chk("rst_instr", Instr, 16'h0);
        @(negedge Pclk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Pclk);
            chk("idle_counter", {12'h0, Counter}, 16'h0);
            chk("idle_instr", Instr, 16'h0);
            chk("idle_run", {15'h0, Run}, 16'h0);
            chk("idle_busy", {15'h0, Busy}, 16'h0);
            chk("idle_halted", {15'h0, Halted}, 16'h0);
        end
    endtask

    // Answers each Run with Done after done_delay cycles until HALT; optionally also
    // raises Done coincident with Run, which must be ignored.
    task automatic run_to_halt(input int done_delay, input bit done_with_run, input bit drop_start);
        int cd;
        int runs;
        bit halted_seen;
        logic [15:0] e;
        cd = -1;
        runs = 0;
        halted_seen = 1'b0;
        for (int cyc = 0; cyc < 600 && !halted_seen; cyc++) begin
            @(negedge Pclk);
            Done = 1'b0;
            if (Halted) begin
                halted_seen = 1'b1;
                if (drop_start) Start = 1'b0;
            end else if (Run) begin
                runs++;
                if (exp_q.size() == 0) begin
                    chk("extra_run", {15'h0, Run}, 16'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pass_instr", Instr, e);
                end
                if (done_with_run) Done = 1'b1;
                cd = done_delay;
            end else if (cd > 0) begin
                chk("wait_busy", {15'h0, Busy}, 16'h1);
                cd--;
                if (cd == 0) Done = 1'b1;
            end
        end
        chk("halt_reached", {15'h0, halted_seen}, 16'h1);
        chk("run_count", runs[15:0], 16'd16);
        chk("halt_counter", {12'h0, Counter}, 16'h000F);
        chk("halt_instr", Instr, 16'hA00F);
        chk("halt_busy", {15'h0, Busy}, 16'h0);
        exp_q.delete();
    endtask

    task automatic test_full_pass();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + i[15:0]);
        @(negedge Pclk);
        Start = 1'b1;
        @(negedge Pclk);
        Start = 1'b0;
        run_to_halt(2, 1'b0, 1'b0);
        repeat (3) @(negedge Pclk);
        chk("halt_stays", {15'h0, Halted}, 16'h1);
        chk("halt_hold_counter", {12'h0, Counter}, 16'h000F);
    endtask

    task automatic test_halt_restart();
        Start = 1'b1;
        @(negedge Pclk);
        Start = 1'b0;
        chk("restart_counter", {12'h0, Counter}, 16'h0);
        chk("restart_halted", {15'h0, Halted}, 16'h0);
        chk("restart_busy", {15'h0, Busy}, 16'h1);
        chk("fetch_run", {15'h0, Run}, 16'h0);
        @(negedge Pclk);
        chk("load_run", {15'h0, Run}, 16'h0);
        @(negedge Pclk);
        exp_q.push_back(16'hA000);
        chk("restart_run", {15'h0, Run}, 16'h1);
        chk("restart_instr", Instr, exp_q.pop_front());
    endtask

    task automatic test_done_stall();
        for (int i = 0; i < 20; i++) begin
            @(negedge Pclk);
            chk("stall_run", {15'h0, Run}, 16'h0);
            chk("stall_busy", {15'h0, Busy}, 16'h1);
            chk("stall_instr", Instr, 16'hA000);
            chk("stall_counter", {12'h0, Counter}, 16'h0);
        end
    endtask

    task automatic test_reset_in_wait();
        bit reached;
        reached = 1'b0;
        for (int cyc = 0; cyc < 300 && !reached; cyc++) begin
            @(negedge Pclk);
            Done = 1'b0;
            if (Run && Counter == 4'h7) reached = 1'b1;
            else if (!Run && Busy && Counter != 4'h7) Done = 1'b1;
        end
        chk("reach_addr7", {15'h0, reached}, 16'h1);
        @(negedge Pclk);
        chk("wait7_counter", {12'h0, Counter}, 16'h0007);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_counter", {12'h0, Counter}, 16'h0);
        chk("async_run", {15'h0, Run}, 16'h0);
        chk("async_busy", {15'h0, Busy}, 16'h0);
        chk("async_instr", Instr, 16'h0);
        @(negedge Pclk);
        Reset = 1'b0;
        Done = 1'b1;
        repeat (4) begin
            @(negedge Pclk);
            chk("post_rst_run", {15'h0, Run}, 16'h0);
            chk("post_rst_busy", {15'h0, Busy}, 16'h0);
        end
        Done = 1'b0;
        Start = 1'b1;
        @(negedge Pclk);
        Start = 1'b0;
        chk("refetch_addr", {12'h0, Mem_addr}, 16'h0);
        repeat (2) @(negedge Pclk);
        chk("refetch_run", {15'h0, Run}, 16'h1);
        chk("refetch_instr", Instr, 16'hA000);
    endtask

    task automatic test_start_held();
        Reset = 1'b1;
        #1;
        @(negedge Pclk);
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + i[15:0]);
        Start = 1'b1;
        run_to_halt(4, 1'b1, 1'b1);
        @(negedge Pclk);
        chk("held_halt_stays", {15'h0, Halted}, 16'h1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset = 1'b0;
        Start = 1'b0;
        Done  = 1'b0;
        test_reset();
        test_full_pass();
        test_halt_restart();
        test_done_stall();
        test_reset_in_wait();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
